lux_sample_scheduler: RTL and testbench
=======================================

Name: lux_sample_scheduler

Overview:
- Sequences a one-shot BH1750 measurement engine (the I2C driver) through a req/done handshake.
- Issues periodic measurement requests, supervises each transaction with a timeout, and averages 2^AVG_LOG2 good samples.
- Drives the roof open/close decision through a hysteresis comparator.
- Sits between the sensor driver and the roof motor controller.

Parameters:
- PERIOD_CYC, 100_000_000: idle cycles between measurements (2 s at 50 MHz).
- TIMEOUT_CYC, 15_000_000: maximum cycles to wait for done/err (300 ms).
- AVG_LOG2, 2: log2 of the number of samples averaged per decision (range 0..4).
- FAIL_LIMIT, 3: consecutive failed transactions that raise o_fault.

Ports:
- i_clk  in  1  system clock, 50 MHz.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_enable  in  1  scheduler enable (level).
- o_meas_req  out  1  one-cycle pulse that starts one sensor transaction.
- i_meas_done  in  1  one-cycle pulse: transaction succeeded, i_meas_data valid.
- i_meas_err  in  1  one-cycle pulse: transaction failed (NACK).
- i_meas_data  in  16  raw illuminance count.
- i_th_high  in  16  open threshold.
- i_th_low  in  16  close threshold.
- o_lux_avg  out  16  latest averaged value.
- o_avg_valid  out  1  one-cycle pulse when o_lux_avg updates.
- o_roof_open  out  1  roof command: 1 = open, 0 = closed.
- o_fault  out  1  sensor fault flag (level).
- o_err_cnt  out  8  total failed transactions; saturates at 255.

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - All outputs go to 0.
  - Accumulator, sample count, consecutive-fail count and timers clear.
  - State goes to IDLE.
  - Reset asserted mid-transaction abandons it; a later i_meas_done is ignored in IDLE.
- States: IDLE, WAIT_PERIOD, REQ, WAIT_DONE, DECIDE.
- IDLE: if i_enable=1, go to WAIT_PERIOD with the period counter at 0.
- WAIT_PERIOD: the counter increments each cycle. When it reaches PERIOD_CYC-1, go to REQ.
- REQ: o_meas_req=1 for exactly this one cycle. Clear the timeout counter and go to WAIT_DONE.
- Measurement interval = PERIOD_CYC + transaction duration + 2 cycles.
- WAIT_DONE, exits:
  - i_meas_err=1: failure.
  - Timeout counter reaches TIMEOUT_CYC-1: failure.
  - Otherwise i_meas_done=1: success.
- If done and err are asserted in the same cycle, err wins; the sample is discarded.
- Success:
  - Sum += i_meas_data (accumulator width 16+AVG_LOG2, never overflows).
  - Sample count increments.
  - Consecutive-fail count clears and o_fault clears.
- Failure:
  - o_err_cnt increments, saturating at 255.
  - Consecutive-fail count increments, saturating at FAIL_LIMIT.
  - On reaching FAIL_LIMIT: o_fault=1 and o_roof_open=0 (safe = closed) on the same edge.
  - The accumulator is untouched.
- After a success or failure:
  - Sample count == 2^AVG_LOG2: go to DECIDE.
  - Otherwise: go to WAIT_PERIOD.
- DECIDE, a single cycle:
  - avg = sum >> AVG_LOG2, truncated.
  - o_lux_avg <= avg and o_avg_valid=1 on the edge leaving DECIDE, so the pulse is high for exactly one cycle.
  - Accumulator and sample count clear.
- Hysteresis, evaluated in DECIDE:
  - avg >= i_th_high: o_roof_open <= 1.
  - avg <= i_th_low: o_roof_open <= 0.
  - Otherwise hold.
  - If i_th_low >= i_th_high (misconfiguration): hold and ignore the thresholds.
  - While o_fault=1, o_roof_open is forced to 0.
- i_enable deasserted:
  - In WAIT_PERIOD or DECIDE: go to IDLE next edge; no further o_meas_req.
  - In WAIT_DONE: complete the transaction (done, err or timeout), updating counters, then go to IDLE.
  - On entering IDLE the accumulator and sample count clear.
  - o_roof_open, o_fault and o_err_cnt hold.
- Thresholds are sampled only in DECIDE.

Optional Feature:
- Macro: LUX_SCALE_EN.
- Defined: the average is converted to lux before output and comparison: lux = (avg * 3413) >> 12 (≈ avg/1.2, 29-bit product, truncated to 16 bits). o_lux_avg and the hysteresis compare use lux.
- Undefined: no multiplier; the raw average is output and compared.

Test Plan (PERIOD_CYC=16, TIMEOUT_CYC=32, AVG_LOG2=2, FAIL_LIMIT=3):
1. Averaging: enable; the model answers each req after 5 cycles with 100, 200, 300, 400 -> o_lux_avg=250 and one o_avg_valid pulse exactly 2 cycles after the 4th done; req pulses spaced 16+5+2 cycles.
2. Hysteresis: th_high=1000, th_low=500; successive averages 1000, 700, 500, 999 -> o_roof_open 1, 1, 0, 0.
3. Fault: the model never answers -> each req times out after 32 cycles; o_err_cnt 1, 2, 3; o_fault=1 and o_roof_open=0 after the 3rd; the next good sample clears o_fault and o_err_cnt stays 3.
4. Collision and saturation: done+err in the same cycle -> counted as an error and the average excludes the sample; 300 forced errors -> o_err_cnt=255.
5. Disable/reset mid-operation: drop i_enable in WAIT_DONE -> no further req after done, IDLE, accumulator cleared; pulse i_rst_n low for 1 cycle -> all outputs 0 on that edge.
6. LUX_SCALE_EN: four samples of 1200 -> o_lux_avg=999; without the macro -> 1200.

Source files
------------

// File: rtl/lux_sample_scheduler.sv
// Periodic BH1750 request sequencer: timeout-supervised transactions, 2^AVG_LOG2 averaging,
// hysteresis roof command and fault tracking. Define LUX_SCALE_EN to output/compare lux instead of raw counts.
module lux_sample_scheduler #(
  parameter int PERIOD_CYC  = 100_000_000,
  parameter int TIMEOUT_CYC = 15_000_000,
  parameter int AVG_LOG2    = 2,
  parameter int FAIL_LIMIT  = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  output logic        o_meas_req,
  input  logic        i_meas_done,
  input  logic        i_meas_err,
  input  logic [15:0] i_meas_data,
  input  logic [15:0] i_th_high,
  input  logic [15:0] i_th_low,
  output logic [15:0] o_lux_avg,
  output logic        o_avg_valid,
  output logic        o_roof_open,
  output logic        o_fault,
  output logic [7:0]  o_err_cnt
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int PER_W = $clog2(PERIOD_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int FL_W  = $clog2(FAIL_LIMIT + 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] N_SAMP   = CNT_W'(2 ** AVG_LOG2);
  localparam logic [FL_W-1:0]  FL_MAX   = FL_W'(FAIL_LIMIT);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_PERIOD, S_REQ, S_WAIT_DONE, S_DECIDE} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Raw average -> reported value (lux = avg * 3413 / 4096 when scaling is built in)
  function automatic logic [15:0] to_output(input logic [15:0] avg);
`ifdef LUX_SCALE_EN
    return 16'(({13'd0, avg} * 29'd3413) >> 12);
`else
    return avg;
`endif
  endfunction

  state_t             r_state, w_next;
  logic [PER_W-1:0]   r_per_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [FL_W-1:0]    r_consec;
  logic [15:0]        r_lux_avg;
  logic               r_avg_valid, r_roof_open, r_fault;
  logic [7:0]         r_err_cnt;

  logic               w_req, w_succ, w_fail, w_tmo;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [FL_W-1:0]    w_consec_inc;
  logic [15:0]        w_avg, w_val;

  assign w_tmo        = (r_tmo_cnt == TMO_LAST);
  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_consec_inc = (r_consec == FL_MAX) ? FL_MAX : r_consec + FL_W'(1);
  assign w_avg        = 16'(r_acc >> AVG_LOG2);
  assign w_val        = to_output(w_avg);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    w_succ = 1'b0;
    w_fail = 1'b0;
    case (r_state)
      S_IDLE:        if (i_enable) w_next = S_WAIT_PERIOD;
      S_WAIT_PERIOD: begin
        if (!i_enable)                  w_next = S_IDLE;
        else if (r_per_cnt == PER_LAST) w_next = S_REQ;
      end
      S_REQ: begin
        w_req  = 1'b1;
        w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // err beats timeout beats done
        if (i_meas_err || w_tmo) w_fail = 1'b1;
        else if (i_meas_done)    w_succ = 1'b1;
        if (w_fail || w_succ) begin
          if (!i_enable)                         w_next = S_IDLE;
          else if (w_succ && w_cnt_inc == N_SAMP) w_next = S_DECIDE;
          else                                   w_next = S_WAIT_PERIOD;
        end
      end
      S_DECIDE:      w_next = i_enable ? S_WAIT_PERIOD : S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_per_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_consec    <= '0;
      r_lux_avg   <= '0;
      r_avg_valid <= 1'b0;
      r_roof_open <= 1'b0;
      r_fault     <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_avg_valid <= 1'b0;
      r_per_cnt   <= (r_state == S_WAIT_PERIOD) ? r_per_cnt + PER_W'(1) : '0;
      r_tmo_cnt   <= (r_state == S_WAIT_DONE)   ? r_tmo_cnt + TMO_W'(1) : '0;
      if (r_state == S_IDLE) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
      if (w_succ) begin
        r_acc    <= r_acc + ACC_W'(i_meas_data);
        r_cnt    <= w_cnt_inc;
        r_consec <= '0;
        r_fault  <= 1'b0;
      end
      if (w_fail) begin
        r_err_cnt <= sat_inc8(r_err_cnt);
        r_consec  <= w_consec_inc;
        if (w_consec_inc == FL_MAX) begin
          r_fault     <= 1'b1;
          r_roof_open <= 1'b0;
        end
      end
      // Thresholds are only looked at here; a misordered pair leaves the roof where it is
      if (r_state == S_DECIDE) begin
        r_lux_avg   <= w_val;
        r_avg_valid <= 1'b1;
        r_acc       <= '0;
        r_cnt       <= '0;
        if (r_fault) r_roof_open <= 1'b0;
        else if (i_th_low < i_th_high) begin
          if (w_val >= i_th_high)     r_roof_open <= 1'b1;
          else if (w_val <= i_th_low) r_roof_open <= 1'b0;
        end
      end
    end
  end

  assign o_meas_req  = w_req;
  assign o_lux_avg   = r_lux_avg;
  assign o_avg_valid = r_avg_valid;
  assign o_roof_open = r_roof_open;
  assign o_fault     = r_fault;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_lux_sample_scheduler.sv
// Scoreboard bench for lux_sample_scheduler: a sensor responder drives transactions, a reference
// model predicts averages/roof/fault/err counts, and a separate monitor checks every o_avg_valid.
module tb_lux_sample_scheduler;
  localparam int P = 16, T = 32, AL = 2, FL = 3, NS = 4;
  localparam int K_DONE = 0, K_ERR = 1, K_TMO = 2, K_BOTH = 3;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, done = 1'b0, err = 1'b0;
  logic [15:0] data = '0, th_hi = '0, th_lo = '0;
  logic        o_meas_req, o_avg_valid, o_roof_open, o_fault;
  logic [15:0] o_lux_avg;
  logic [7:0]  o_err_cnt;

  lux_sample_scheduler #(.PERIOD_CYC(P), .TIMEOUT_CYC(T), .AVG_LOG2(AL), .FAIL_LIMIT(FL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .o_meas_req(o_meas_req),
    .i_meas_done(done), .i_meas_err(err), .i_meas_data(data),
    .i_th_high(th_hi), .i_th_low(th_lo), .o_lux_avg(o_lux_avg), .o_avg_valid(o_avg_valid),
    .o_roof_open(o_roof_open), .o_fault(o_fault), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int val; int roof; int cyc; } exp_t;
  exp_t sbq[$];

  int n_checks = 0, n_err = 0;
  int m_samples[$];
  int m_err = 0, m_consec = 0, m_fault = 0, m_roof = 0, exp_req = -1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int scale(input int a);
`ifdef LUX_SCALE_EN
    return (a * 3413) / 4096;
`else
    return a;
`endif
  endfunction

  // Reference model: applies one transaction outcome that happened in cycle oc
  task automatic model_outcome(input bit fail, input int d, input int oc);
    int sum, v;
    if (fail) begin
      m_err    = (m_err < 255) ? m_err + 1 : 255;
      m_consec = (m_consec < FL) ? m_consec + 1 : FL;
      if (m_consec == FL) begin m_fault = 1; m_roof = 0; end
    end else begin
      m_samples.push_back(d);
      m_consec = 0;
      m_fault  = 0;
    end
    if (!en) begin
      m_samples.delete();
      exp_req = -1;
    end else if (!fail && m_samples.size() == NS) begin
      sum = 0;
      foreach (m_samples[i]) sum += m_samples[i];
      v = scale(sum / NS);
      if (m_fault != 0) m_roof = 0;
      else if (int'(th_lo) < int'(th_hi)) begin
        if (v >= int'(th_hi))      m_roof = 1;
        else if (v <= int'(th_lo)) m_roof = 0;
      end
      sbq.push_back('{v, m_roof, oc + 2});
      m_samples.delete();
      exp_req = oc + P + 2;
    end else begin
      exp_req = oc + P + 1;
    end
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (o_meas_req) seen = 1'b1;
    end
    chk("req_seen", int'(seen), 1);
  endtask

  task automatic txn(input int kind, input int d, input int gap, input bit drop);
    bit seen;
    int oc, old_err;
    wait_req(seen);
    if (!seen) return;
    chk("req_cycle", cyc, exp_req);
    old_err = m_err;
    if (drop) en = 1'b0;
    if (kind == K_TMO) begin
      repeat (T) @(negedge clk);
      chk("err_before_timeout", int'(o_err_cnt), old_err);
      oc = cyc;
      @(negedge clk);
    end else begin
      repeat (gap + 1) @(posedge clk);
      #1;
      data = 16'(d);
      done = (kind == K_DONE || kind == K_BOTH);
      err  = (kind == K_ERR  || kind == K_BOTH);
      oc = cyc;
      @(posedge clk);
      #1;
      done = 1'b0;
      err  = 1'b0;
      @(negedge clk);
    end
    model_outcome(kind != K_DONE, d, oc);
    chk("err_cnt", int'(o_err_cnt), m_err);
    chk("fault", int'(o_fault), m_fault);
    if (kind != K_DONE) chk("roof_after_fail", int'(o_roof_open), m_roof);
  endtask

  task automatic start_en();
    @(posedge clk);
    #1;
    en = 1'b1;
    exp_req = cyc + P + 1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   int'(o_meas_req), 0);
    chk({tag, "_avg"},   int'(o_lux_avg), 0);
    chk({tag, "_valid"}, int'(o_avg_valid), 0);
    chk({tag, "_roof"},  int'(o_roof_open), 0);
    chk({tag, "_fault"}, int'(o_fault), 0);
    chk({tag, "_errcnt"}, int'(o_err_cnt), 0);
  endtask

  // Monitor: every averaged output is popped from the scoreboard and compared
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_avg_valid) begin
        if (sbq.size() == 0) chk("unexpected_avg_valid", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("lux_avg", int'(o_lux_avg), e.val);
          chk("roof_at_avg", int'(o_roof_open), e.roof);
          chk("avg_valid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hv[4];
    int r;
    bit seen, saw;
    hv = '{1000, 700, 500, 999};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");

    th_hi = 16'd1000;
    th_lo = 16'd500;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    exp_req = cyc + P + 1;

    // Averaging: 100,200,300,400
    for (int k = 0; k < 4; k++) txn(K_DONE, 100 * (k + 1), 5, 1'b0);

    // Hysteresis: averages 1000, 700, 500, 999
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 4; k++) txn(K_DONE, hv[g], 5, 1'b0);

    // Randomized traffic with random (sometimes inverted) thresholds
    for (int n = 0; n < 24; n++) begin
      @(posedge clk);
      #1;
      th_hi = 16'($urandom_range(0, 3000));
      th_lo = 16'($urandom_range(0, 3000));
      r = int'($urandom_range(0, 9));
      txn((r == 0) ? K_ERR : (r == 1) ? K_BOTH : (r == 2) ? K_TMO : K_DONE,
          int'($urandom_range(0, 3000)), int'($urandom_range(0, 20)), 1'b0);
    end

    // Fault: open the roof, then three timeouts, then one good sample
    @(posedge clk);
    #1;
    th_hi = 16'd1000;
    th_lo = 16'd500;
    while (m_samples.size() != 0) txn(K_DONE, 1500, 3, 1'b0);
    for (int k = 0; k < 4; k++) txn(K_DONE, 1500, 3, 1'b0);
    for (int k = 0; k < 3; k++) txn(K_TMO, 0, 0, 1'b0);
    txn(K_DONE, 1500, 2, 1'b0);

    // Collision: done+err counts as error, sample excluded
    txn(K_BOTH, 60000, 2, 1'b0);
    while (m_samples.size() != 0) txn(K_DONE, 800, 1, 1'b0);

    // Error counter saturation
    for (int k = 0; k < 300; k++) txn(K_ERR, 0, 0, 1'b0);
    chk("err_cnt_saturated", int'(o_err_cnt), 255);

    // Disable during WAIT_DONE: partial samples dropped, no further requests
    txn(K_DONE, 1500, 2, 1'b0);
    txn(K_DONE, 1500, 2, 1'b0);
    txn(K_DONE, 1500, 4, 1'b1);
    saw = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (o_meas_req) saw = 1'b1;
    end
    chk("no_req_when_disabled", int'(saw), 0);
    start_en();
    for (int k = 0; k < 4; k++) txn(K_DONE, 1200, 5, 1'b0);

    // One-cycle reset while a transaction is outstanding; a late done is ignored
    wait_req(seen);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    m_samples.delete();
    m_err = 0; m_consec = 0; m_fault = 0; m_roof = 0;
    @(posedge clk);
    #1;
    data = 16'd5;
    done = 1'b1;
    @(posedge clk);
    #1;
    done = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_done_errcnt", int'(o_err_cnt), 0);
    chk("late_done_no_req", int'(o_meas_req), 0);
    @(posedge clk);
    #1;
    th_hi = 16'd1000;
    th_lo = 16'd500;
    start_en();
    for (int k = 0; k < 4; k++) txn(K_DONE, 2000, 1, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
